// File: rtl/stats_sequencer.sv
// Statistics sequencer: streams the capture buffer, accumulates sum/min/max,
// then divides the sum by SAMPLES with a serial restoring divider.
module stats_sequencer #(
    parameter  int SAMPLES = 80,
    parameter  int DATA_W  = 12,
    localparam int ADDR_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
    localparam int SUM_W   = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] average,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] max
);

    localparam int REM_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SAMPLES - 1);
    localparam logic [REM_W:0]    DIVISOR = (REM_W + 1)'(SAMPLES);
    localparam logic [CNT_W-1:0]  DIV_END = CNT_W'(SUM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SUM_W-1:0]  r_sum;
    logic [REM_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cap;
    logic              r_first;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [REM_W:0]    w_trial;
    logic [REM_W:0]    w_diff;
    logic              w_fit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  if (rd_addr == LAST) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DIV;
            S_DIV:   if (r_cnt == DIV_END) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_sum doubles as the quotient shift register during S_DIV
    always_comb begin
        w_trial = {r_rem, r_sum[SUM_W-1]};
        w_diff  = w_trial - DIVISOR;
        w_fit   = (w_trial >= DIVISOR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            average <= '0;
            min     <= '0;
            max     <= '0;
            r_sum   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_cap   <= 1'b0;
            r_first <= 1'b0;
            r_min   <= '0;
            r_max   <= '0;
        end else begin
            done  <= 1'b0;
            r_cap <= rd_en;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        r_sum   <= '0;
                        r_first <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_addr == LAST) begin
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_sum <= {r_sum[SUM_W-2:0], w_fit};
                    r_rem <= w_fit ? w_diff[REM_W-1:0] : w_trial[REM_W-1:0];
                end
                S_DONE: begin
                    average <= r_sum[DATA_W-1:0];
                    min     <= r_min;
                    max     <= r_max;
                    done    <= 1'b1;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
            // read data trails the address by one cycle
            if (r_cap) begin
                r_sum <= r_sum + {{ADDR_W{1'b0}}, rd_data};
                if (r_first) begin
                    r_first <= 1'b0;
                    r_min   <= rd_data;
                    r_max   <= rd_data;
                end else begin
                    if (rd_data < r_min) r_min <= rd_data;
                    if (rd_data > r_max) r_max <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_stats_sequencer.sv
// Randomized bench for stats_sequencer with a behavioural buffer model
// and a reference computed directly from the buffer contents.
module tb_stats_sequencer;

    localparam int SAMPLES = 80;
    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 7;
    localparam int LAT     = 101;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] d_avg;
    logic [DATA_W-1:0] d_min;
    logic [DATA_W-1:0] d_max;

    logic [DATA_W-1:0] mem [SAMPLES];

    logic [DATA_W-1:0] last_avg;
    logic [DATA_W-1:0] last_min;
    logic [DATA_W-1:0] last_max;
    logic              last_valid;

    int total = 0;
    int bad   = 0;

    stats_sequencer #(.SAMPLES(SAMPLES), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .average (d_avg),
        .min     (d_min),
        .max     (d_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: single pulse, 1: extra ignored pulses, 2: start held high
    task automatic run(input string nm, input int mode);
        int sum, emin, emax;
        int first_done, second_done, dones, rdcnt;
        int addr_bad, busy_bad, hold_bad, restart_ok, last_n;
        int g_avg, g_min, g_max, g_valid;
        sum = 0;
        emin = 4095;
        emax = 0;
        for (int k = 0; k < SAMPLES; k++) begin
            sum += int'(mem[k]);
            if (int'(mem[k]) < emin) emin = int'(mem[k]);
            if (int'(mem[k]) > emax) emax = int'(mem[k]);
        end
        first_done = -1;
        second_done = -1;
        dones = 0;
        rdcnt = 0;
        addr_bad = 0;
        busy_bad = 0;
        hold_bad = 0;
        restart_ok = 0;
        g_avg = -1;
        g_min = -1;
        g_max = -1;
        g_valid = -1;
        last_n = (mode == 2) ? 205 : 110;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= last_n; n++) begin
            if (n > 0) @(posedge clk);
            #1;
            if (mode == 2) start = (n < 150);
            else if (mode == 1) start = (n == 10 || n == 100);
            else start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_done = n;
                    g_avg = int'(d_avg);
                    g_min = int'(d_min);
                    g_max = int'(d_max);
                    g_valid = int'(valid);
                end else begin
                    second_done = n;
                end
            end
            if (n < LAT) begin
                if (!busy) busy_bad++;
                if (d_avg !== last_avg || d_min !== last_min ||
                    d_max !== last_max || valid !== last_valid)
                    hold_bad++;
            end
            if (n == LAT && busy) busy_bad++;
            if (n <= LAT && rd_en) begin
                rdcnt++;
                if (int'(rd_addr) != n) addr_bad++;
            end
            if (mode == 2 && n == LAT + 1 && rd_en && rd_addr == 0 && busy)
                restart_ok = 1;
        end
        start = 1'b0;
        check({nm, "_latency"}, first_done, LAT);
        check({nm, "_dones"}, dones, (mode == 2) ? 2 : 1);
        check({nm, "_rdcnt"}, rdcnt, SAMPLES);
        check({nm, "_addrseq"}, addr_bad, 0);
        check({nm, "_busy"}, busy_bad, 0);
        check({nm, "_hold"}, hold_bad, 0);
        check({nm, "_avg"}, g_avg, sum / SAMPLES);
        check({nm, "_min"}, g_min, emin);
        check({nm, "_max"}, g_max, emax);
        check({nm, "_valid"}, g_valid, 1);
        if (mode == 2) begin
            check({nm, "_restart"}, restart_ok, 1);
            check({nm, "_done2"}, second_done, 2 * LAT + 1);
        end
        last_avg = DATA_W'(sum / SAMPLES);
        last_min = DATA_W'(emin);
        last_max = DATA_W'(emax);
        last_valid = 1'b1;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int k = 0; k < SAMPLES; k++)
            mem[k] = DATA_W'($urandom_range(hi, lo));
    endtask

    task automatic abort_run();
        int dn;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_rden", int'(rd_en), 0);
        check("abort_outs", int'(d_avg) + int'(d_min) + int'(d_max), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_nodone", dn, 0);
        last_avg = '0;
        last_min = '0;
        last_max = '0;
        last_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int k = 0; k < SAMPLES; k++) mem[k] = '0;
        last_avg = '0;
        last_min = '0;
        last_max = '0;
        last_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_rden", int'(rd_en), 0);
        check("rst_addr", int'(rd_addr), 0);
        check("rst_outs", int'(d_avg) + int'(d_min) + int'(d_max), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < SAMPLES; k++) mem[k] = DATA_W'(k);
        run("ramp", 0);
        check("ramp_avg_const", int'(d_avg), 39);

        for (int k = 0; k < SAMPLES; k++) mem[k] = 12'd4095;
        run("full", 0);

        for (int k = 0; k < SAMPLES; k++) mem[k] = 12'd100;
        mem[37] = 12'd4000;
        run("spike", 0);
        check("spike_avg_const", int'(d_avg), 148);
        mem[79] = 12'd3;
        run("spike_lo", 0);

        for (int k = 0; k < SAMPLES; k++) mem[k] = DATA_W'(k);
        run("ignore", 1);

        fill_rand(0, 4095);
        run("held", 2);

        abort_run();
        fill_rand(0, 4095);
        run("post_rst", 0);

        for (int r = 0; r < 4; r++) begin
            fill_rand(r * 500, r * 500 + 40);
            run("rand", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stats_sequencer.md
Name: stats_sequencer

Overview:
- Multi-cycle measurement controller for the oscilloscope statistics path.
- On a start request it walks the captured sample buffer one address per cycle and accumulates sum, minimum and maximum.
- It then runs a sequential restoring division to produce the average, and publishes average/min/max with a done pulse.
- Sits between the capture buffer (synchronous-read RAM) and the on-screen measurement display logic.

Parameters:
- SAMPLES, 80: number of samples per measurement, at least 1.
- DATA_W, 12: sample width in bits.
- Derived localparam ADDR_W = max(1, $clog2(SAMPLES)); 7 at default.
- Derived localparam SUM_W = DATA_W + ADDR_W; 19 at default.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results updated on the same edge.
- valid  out  1  high once any measurement has completed; cleared only by rst.
- rd_en  out  1  buffer read enable.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  DATA_W  buffer read data; returned 1 cycle after rd_en/rd_addr.
- average  out  DATA_W  floor(sum / SAMPLES).
- min  out  DATA_W  smallest sample.
- max  out  DATA_W  largest sample.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE. busy, done, valid, rd_en, rd_addr, average, min and max are all 0. Internal sum, remainder and counters are also 0.
- IDLE: if start=1, go to READ. Set rd_en=1, rd_addr=0, clear sum.
- READ, one address per cycle:
  - Increment rd_addr each cycle while rd_addr < SAMPLES-1.
  - After issuing SAMPLES-1, drop rd_en and go to DRAIN.
  - Capture rd_data for address k on the cycle after it is issued, and add it into sum (SUM_W wide, no overflow possible).
  - Sample 0 loads min_r and max_r directly; min is never initialised to 0.
  - Later samples: min_r takes rd_data if rd_data < min_r; max_r takes rd_data if rd_data > max_r. All comparisons are unsigned.
- DRAIN, 1 cycle: accumulate the final returned sample, then go to DIV.
- DIV, exactly SUM_W cycles: restoring division of sum by the constant SAMPLES, MSB first, one quotient bit per cycle. Go to DONE.
- DONE, 1 cycle:
  - average <= quotient[DATA_W-1:0], which always fits.
  - min <= min_r, max <= max_r.
  - done=1, valid<=1, busy<=0, then return to IDLE.
- Latency: done is high exactly SAMPLES+SUM_W+2 cycles after the edge that sampled start (101 at defaults). busy is high for all cycles in between.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new measurement is accepted on the first IDLE cycle after DONE. Back-to-back measurements are therefore spaced by latency+1.
- Outputs: hold their last result until the next DONE; they do not change during a run.
- rst mid-operation: immediate abort. All outputs go to their reset values and valid=0. No done pulse is produced.
- SAMPLES=1: READ lasts 1 cycle. average=min=max=the single sample.
- rd_addr never exceeds SAMPLES-1.

Test Plan:
- Buffer[k]=k for k=0..79, pulse start -> after 101 cycles done=1 for one cycle, sum 3160, average=39, min=0, max=79, valid=1.
- All samples 4095 -> average=4095, min=4095, max=4095 (checks full SUM_W accumulation, 327600 with no wrap).
- All samples 100 except buffer[37]=4000 and buffer[0]=100 -> sum 11900, average=148, min=100, max=4000. Then buffer[79]=3 and rerun -> min=3, with the previous results held until the new done.
- start pulsed again at cycles 10 and 100 of a run -> ignored: exactly one done, rd_addr sequence 0..79 issued once. With start held high, the second run's first rd_en appears 1 cycle after done.
- rst asserted asynchronously at cycle 50 of a run -> outputs, busy and valid go to 0 immediately with no done. A later start gives a correct result with the exact 101-cycle latency.
- Check rd_addr increments by 1 per cycle with rd_en high for exactly 80 consecutive cycles. busy stays high from the cycle after start until done.
